i2c_pcf8591_target: RTL and testbench

//  I2C target (slave) that emulates a PCF8591 ADC/DAC on the bus, so the PCF8591 read path can be driven in simulation and on-board loopback.

---
 rtl/pcf8591_pkg.sv | 29 ++
 rtl/i2c_bus_sync.sv | 57 +++++
 rtl/i2c_pcf8591_target.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_pcf8591_target.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcf8591_pkg.sv
// Shared definitions for the PCF8591 target emulation.
//   BASE_ADDR        upper four bits of the 7-bit device address
//   CTRL_*           bit positions inside the control byte
//   RESET_SAMPLE_DEF default holding-register contents after reset
//   state_e          byte-level FSM states of the target
package pcf8591_pkg;

  localparam logic [3:0]  BASE_ADDR        = 4'b1001;

  localparam int unsigned CTRL_CH_LSB      = 0;
  localparam int unsigned CTRL_CH_MSB      = 1;
  localparam int unsigned CTRL_AUTOINC     = 2;
  localparam int unsigned CTRL_MODE_LSB    = 4;
  localparam int unsigned CTRL_MODE_MSB    = 5;
  localparam int unsigned CTRL_DAC_EN      = 6;

  localparam logic [7:0]  RESET_SAMPLE_DEF = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK
  } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises the raw SCL/SDA pad inputs into the clk domain and derives
// bus events from the synchronised values.
//   clk, reset   system clock, asynchronous active-low reset
//   scl_i, sda_i raw pad inputs
//   sda_s        synchronised SDA level
//   scl_rise     1-cycle pulse on a synchronised SCL rising edge
//   scl_fall     1-cycle pulse on a synchronised SCL falling edge
//   start_det    SDA fell while SCL stayed high
//   stop_det     SDA rose while SCL stayed high
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
  end

  // Idle bus level is high, so all stages reset to 1 to avoid a false
  // START/STOP right after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_pcf8591_target.sv
// I2C target emulating a PCF8591 ADC/DAC. Writes set the control byte and
// the DAC byte; reads return the previously latched conversion while the
// currently selected channel is latched into the holding register.
//   clk, reset  system clock (>= 16x SCL), asynchronous active-low reset
//   scl_i/sda_i pad inputs; sda_oe = 1 pulls SDA low
//   adc_data    four 8-bit samples, ch n at [8n+7:8n]
//   ctrl_reg    last control byte, dac_en = ctrl_reg[6]
//   dac_value   last DAC byte
//   rd_strobe   1-cycle pulse per sample latched into the holding register
//   busy        high from an address match until the next START or STOP
module i2c_pcf8591_target
  import pcf8591_pkg::*;
#(
  parameter logic [2:0]  A_PINS       = 3'b000,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [7:0]  RESET_SAMPLE = RESET_SAMPLE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [31:0] adc_data,
  output logic [7:0]  ctrl_reg,
  output logic [7:0]  dac_value,
  output logic        dac_en,
  output logic        rd_strobe,
  output logic        busy
);

  localparam logic [6:0] DEV_ADDR = {BASE_ADDR, A_PINS};

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] ch_q, ch_d;
  logic [7:0] holding_q, holding_d;
  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] dac_q, dac_d;
  logic       oe_q, oe_d;
  logic       strobe_q, strobe_d;
  logic       busy_q, busy_d;
  logic       load_rd;
  logic [7:0] adc_ch;

  assign adc_ch = adc_data[{ch_q, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    idx_d     = idx_q;
    ch_d      = ch_q;
    holding_d = holding_q;
    ctrl_d    = ctrl_q;
    dac_d     = dac_q;
    oe_d      = oe_q;
    strobe_d  = 1'b0;
    busy_d    = busy_q;
    load_rd   = 1'b0;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR, ST_WR_BYTE: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            rx_d      = {rx_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (state_q == ST_ADDR) begin
              if (rx_q[7:1] == DEV_ADDR) begin
                state_d = ST_ADDR_ACK;
                oe_d    = 1'b1;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              state_d = ST_WR_ACK;
              oe_d    = 1'b1;
              if (idx_q == 2'd0) begin
                ctrl_d = rx_q;
                ch_d   = rx_q[CTRL_CH_MSB:CTRL_CH_LSB];
              end else begin
                dac_d = rx_q;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            oe_d = 1'b0;
            if (rx_q[0]) begin
              load_rd = 1'b1;
            end else begin
              state_d   = ST_WR_BYTE;
              idx_d     = 2'd0;
              bit_cnt_d = '0;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            oe_d      = 1'b0;
            state_d   = ST_WR_BYTE;
            bit_cnt_d = '0;
            if (idx_q != 2'd2) idx_d = idx_q + 2'd1;
          end
        end
        ST_RD_BYTE: begin
          // MSB is already on the bus from entry; each later fall shifts out
          // the next bit, and the fall after the 8th rise releases SDA.
          if (scl_rise && bit_cnt_q != 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = ST_RD_ACK;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
              oe_d = ~tx_q[6];
            end
          end
        end
        ST_RD_ACK: begin
          // A NACK exits on the rise; reaching the fall means ACK was seen.
          if (scl_rise && sda_s) state_d = ST_IDLE;
          else if (scl_fall)     load_rd = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase

      if (load_rd) begin
        state_d   = ST_RD_BYTE;
        bit_cnt_d = '0;
        tx_d      = holding_q;
        oe_d      = ~holding_q[7];
        holding_d = adc_ch;
        strobe_d  = 1'b1;
        if (ctrl_q[CTRL_AUTOINC]) ch_d = ch_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      idx_q     <= '0;
      ch_q      <= '0;
      holding_q <= RESET_SAMPLE;
      ctrl_q    <= '0;
      dac_q     <= '0;
      oe_q      <= 1'b0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      idx_q     <= idx_d;
      ch_q      <= ch_d;
      holding_q <= holding_d;
      ctrl_q    <= ctrl_d;
      dac_q     <= dac_d;
      oe_q      <= oe_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
    end
  end

  // START/STOP release SDA in the detection cycle, ahead of the register.
  assign sda_oe    = oe_q & ~(start_det | stop_det);
  assign ctrl_reg  = ctrl_q;
  assign dac_value = dac_q;
  assign dac_en    = ctrl_q[CTRL_DAC_EN];
  assign rd_strobe = strobe_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_pcf8591_target.sv
// Directed bench for i2c_pcf8591_target: a bit-banged I2C controller drives
// the bus, SDA is resolved as a wired-AND with the target's pull-down.
module tb_i2c_pcf8591_target;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [31:0] adc_data = 32'h44332211;
  logic [7:0]  ctrl_reg, dac_value;
  logic        dac_en, rd_strobe, busy;

  int unsigned vectors = 0;
  int unsigned errors = 0;
  int unsigned strobe_total = 0;
  int unsigned oe_total = 0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_strobe) strobe_total <= strobe_total + 1;
    if (sda_oe)    oe_total     <= oe_total + 1;
  end

  i2c_pcf8591_target #(
    .A_PINS      (3'b000),
    .SYNC_STAGES (2),
    .RESET_SAMPLE(8'h80)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .adc_data (adc_data),
    .ctrl_reg (ctrl_reg),
    .dac_value(dac_value),
    .dac_en   (dac_en),
    .rd_strobe(rd_strobe),
    .busy     (busy)
  );

  task automatic wait_q();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_q();
    scl   = 1'b1; wait_q();
    wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    b = sda_line; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int unsigned i = 0; i < 8; i++) write_bit(d[7-i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(ack);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe got %b want 0", sda_oe); end
    vectors++; if (ctrl_reg !== 8'h00) begin errors++; $display("FAIL rst_ctrl got %h want 00", ctrl_reg); end
    vectors++; if (dac_value !== 8'h00) begin errors++; $display("FAIL rst_dac got %h want 00", dac_value); end
    vectors++; if (dac_en !== 1'b0) begin errors++; $display("FAIL rst_dac_en got %b want 0", dac_en); end
    vectors++; if (rd_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe got %b want 0", rd_strobe); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    reset = 1'b1;
    wait_q();
  endtask

  task automatic test_write();
    logic ack;
    i2c_start();
    write_byte(8'h90, ack);
    vectors++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b want 0", ack); end
    write_byte(8'h40, ack);
    vectors++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_ctrl_ack got %b want 0", ack); end
    write_byte(8'hA5, ack);
    vectors++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_dac_ack got %b want 0", ack); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_mid got %b want 1", busy); end
    i2c_stop();
    vectors++; if (ctrl_reg !== 8'h40) begin errors++; $display("FAIL wr_ctrl got %h want 40", ctrl_reg); end
    vectors++; if (dac_en !== 1'b1) begin errors++; $display("FAIL wr_dac_en got %b want 1", dac_en); end
    vectors++; if (dac_value !== 8'hA5) begin errors++; $display("FAIL wr_dac got %h want a5", dac_value); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_stop got %b want 0", busy); end
  endtask

  task automatic test_bad_addr();
    logic ack;
    int unsigned oe0;
    oe0 = oe_total;
    i2c_start();
    write_byte(8'h92, ack);
    vectors++; if (ack !== 1'b1) begin errors++; $display("FAIL bad_addr_ack got %b want 1", ack); end
    write_byte(8'h00, ack);
    vectors++; if (ack !== 1'b1) begin errors++; $display("FAIL bad_addr_data_ack got %b want 1", ack); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_addr_busy got %b want 0", busy); end
    i2c_stop();
    vectors++; if (oe_total - oe0 !== 0) begin errors++; $display("FAIL bad_addr_oe got %0d cycles want 0", oe_total - oe0); end
    vectors++; if (ctrl_reg !== 8'h40) begin errors++; $display("FAIL bad_addr_ctrl got %h want 40", ctrl_reg); end
  endtask

  task automatic test_read_fixed();
    logic ack;
    logic [7:0] d;
    logic [7:0] exp_d [3];
    int unsigned s0;
    exp_d[0] = 8'h80; exp_d[1] = 8'h22; exp_d[2] = 8'h22;
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h01, ack);
    i2c_stop();
    vectors++; if (ctrl_reg !== 8'h01) begin errors++; $display("FAIL rdf_ctrl got %h want 01", ctrl_reg); end
    vectors++; if (dac_en !== 1'b0) begin errors++; $display("FAIL rdf_dac_en got %b want 0", dac_en); end
    s0 = strobe_total;
    i2c_start();
    write_byte(8'h91, ack);
    vectors++; if (ack !== 1'b0) begin errors++; $display("FAIL rdf_addr_ack got %b want 0", ack); end
    for (int unsigned i = 0; i < 3; i++) begin
      read_byte(d, (i == 2) ? 1'b1 : 1'b0);
      vectors++;
      if (d !== exp_d[i]) begin errors++; $display("FAIL rdf_byte%0d got %h want %h", i, d, exp_d[i]); end
    end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rdf_busy_nack got %b want 1", busy); end
    i2c_stop();
    vectors++; if (strobe_total - s0 !== 3) begin errors++; $display("FAIL rdf_strobes got %0d want 3", strobe_total - s0); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rdf_busy_stop got %b want 0", busy); end
    vectors++; if (dac_value !== 8'hA5) begin errors++; $display("FAIL rdf_dac got %h want a5", dac_value); end
  endtask

  task automatic test_read_autoinc();
    logic ack;
    logic [7:0] d;
    logic [7:0] exp_d [5];
    int unsigned s0;
    exp_d[0] = 8'h22; exp_d[1] = 8'h11; exp_d[2] = 8'h22; exp_d[3] = 8'h33; exp_d[4] = 8'h44;
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h04, ack);
    i2c_stop();
    s0 = strobe_total;
    i2c_start();
    write_byte(8'h91, ack);
    for (int unsigned i = 0; i < 5; i++) begin
      read_byte(d, (i == 4) ? 1'b1 : 1'b0);
      vectors++;
      if (d !== exp_d[i]) begin errors++; $display("FAIL rda_byte%0d got %h want %h", i, d, exp_d[i]); end
    end
    i2c_stop();
    vectors++; if (strobe_total - s0 !== 5) begin errors++; $display("FAIL rda_strobes got %0d want 5", strobe_total - s0); end
  endtask

  task automatic test_rep_start();
    logic ack;
    logic [7:0] d;
    int unsigned s0;
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h04, ack);
    write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
    s0 = strobe_total;
    i2c_start();
    write_byte(8'h91, ack);
    vectors++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack got %b want 0", ack); end
    read_byte(d, 1'b1);
    vectors++; if (d !== 8'h11) begin errors++; $display("FAIL rs_read got %h want 11", d); end
    i2c_stop();
    vectors++; if (dac_value !== 8'hA5) begin errors++; $display("FAIL rs_dac got %h want a5", dac_value); end
    vectors++; if (ctrl_reg !== 8'h04) begin errors++; $display("FAIL rs_ctrl got %h want 04", ctrl_reg); end
    vectors++; if (strobe_total - s0 !== 1) begin errors++; $display("FAIL rs_strobes got %0d want 1", strobe_total - s0); end
  endtask

  task automatic test_reset_mid();
    logic ack;
    logic [7:0] d;
    logic [7:0] a;
    a = 8'h91;
    i2c_start();
    for (int unsigned i = 0; i < 8; i++) write_bit(a[7-i]);
    sda_m = 1'b1;
    wait_q();
    vectors++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rm_ack_drive got %b want 1", sda_oe); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre got %b want 1", busy); end
    @(posedge clk);
    #1 reset = 1'b0;
    #2;
    vectors++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rm_sda_oe got %b want 0", sda_oe); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
    vectors++; if (ctrl_reg !== 8'h00) begin errors++; $display("FAIL rm_ctrl got %h want 00", ctrl_reg); end
    vectors++; if (dac_value !== 8'h00) begin errors++; $display("FAIL rm_dac got %h want 00", dac_value); end
    vectors++; if (dac_en !== 1'b0) begin errors++; $display("FAIL rm_dac_en got %b want 0", dac_en); end
    vectors++; if (rd_strobe !== 1'b0) begin errors++; $display("FAIL rm_strobe got %b want 0", rd_strobe); end
    #10 reset = 1'b1;
    scl = 1'b1;
    wait_q();
    wait_q();
    i2c_start();
    write_byte(8'h91, ack);
    vectors++; if (ack !== 1'b0) begin errors++; $display("FAIL rm_addr_ack got %b want 0", ack); end
    read_byte(d, 1'b1);
    vectors++; if (d !== 8'h80) begin errors++; $display("FAIL rm_holding got %h want 80", d); end
    i2c_stop();
  endtask

  initial begin
    test_reset();
    test_write();
    test_bad_addr();
    test_read_fixed();
    test_read_autoinc();
    test_rep_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
